uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 134 +++++++++++++
 tb/tb_uart_rx.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver.
// A 2-flop synchronizer feeds a mid-bit sampling FSM. One-cycle pulses mark a
// completed frame (rx_done_tick_o) or a low stop bit (rx_frame_err_o).
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 10
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       rx_i,
  output logic [7:0] rx_dout_o,
  output logic       rx_done_tick_o,
  output logic       rx_frame_err_o,
  output logic       rx_active_o
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [2:0]    idx_q, idx_n;
  logic [7:0]    sh_q, sh_n;
  logic [7:0]    dout_n;
  logic          done_n, err_n;

  logic          sync1_q, sync2_q, rx_prev_q;
  logic          rx_s;

  assign rx_s = sync2_q;

  // Synchronize the line and keep the previous synchronized value for edge detection.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= rx_i;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
    end
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      idx_q          <= '0;
      sh_q           <= '0;
      rx_dout_o      <= '0;
      rx_done_tick_o <= 1'b0;
      rx_frame_err_o <= 1'b0;
      rx_active_o    <= 1'b0;
    end else begin
      state_q        <= state_n;
      cnt_q          <= cnt_n;
      idx_q          <= idx_n;
      sh_q           <= sh_n;
      rx_dout_o      <= dout_n;
      rx_done_tick_o <= done_n;
      rx_frame_err_o <= err_n;
      rx_active_o    <= (state_q != IDLE);
    end
  end

  // Next-state and datapath decisions; sampling happens only at counter terminal values.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    idx_n   = idx_q;
    sh_n    = sh_q;
    dout_n  = rx_dout_o;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_prev_q && !rx_s) begin
          cnt_n   = '0;
          state_n = START;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_n = '0;
          if (!rx_s) begin
            idx_n   = '0;
            state_n = DATA;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          sh_n  = {rx_s, sh_q[7:1]};
          cnt_n = '0;
          idx_n = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_n = STOP;
          end
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
          if (rx_s) begin
            dout_n = sh_q;
            done_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx. Stimulus pushes the expected
// pulse (kind + rx_dout_o value) and a monitor pops on every output pulse.
module tb_uart_rx;

  localparam int CPB = 10;

  logic       clk;
  logic       rstn;
  logic       rx;
  logic [7:0] dout;
  logic       done_tick;
  logic       frame_err;
  logic       active;

  typedef struct {
    logic       err;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .rx_i           (rx),
    .rx_dout_o      (dout),
    .rx_done_tick_o (done_tick),
    .rx_frame_err_o (frame_err),
    .rx_active_o    (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every output pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rstn && (done_tick || frame_err)) begin
      checks++;
      if (done_tick && frame_err) begin
        errors++;
        $display("FAIL pulse_excl: done=1 err=1 together, required only one");
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: done=%0b err=%0b dout=%02h, required no pulse",
                 done_tick, frame_err, dout);
      end else begin
        e = sb.pop_front();
        if (frame_err !== e.err || dout !== e.data) begin
          errors++;
          $display("FAIL frame_event: got err=%0b dout=%02h, required err=%0b dout=%02h",
                   frame_err, dout, e.err, e.data);
        end
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic push(input logic err, input logic [7:0] data);
    exp_t x;
    x.err  = err;
    x.data = data;
    sb.push_back(x);
  endtask

  task automatic idle(input int bits);
    rx = 1'b1;
    repeat (bits * CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  initial begin
    rx   = 1'b1;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_dout", {24'd0, dout}, 32'h00);
    check("reset_done", {31'd0, done_tick}, 32'd0);
    check("reset_err", {31'd0, frame_err}, 32'd0);
    check("reset_active", {31'd0, active}, 32'd0);
    rstn = 1'b1;
    idle(2);

    // Clean frame
    push(1'b0, 8'h51);
    send_frame(8'h51, 1'b1);
    idle(2);

    // Framing error: dout must keep 0x51
    push(1'b1, 8'h51);
    send_frame(8'h5A, 1'b0);
    idle(2);
    check("ferr_dout_hold", {24'd0, dout}, 32'h51);

    // Reset during data bit 4 of 0xFF
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (4 * CPB + CPB / 2) @(negedge clk);
    check("midframe_active", {31'd0, active}, 32'd1);
    rstn = 1'b0;
    #1;
    check("midrst_dout", {24'd0, dout}, 32'h00);
    check("midrst_active", {31'd0, active}, 32'd0);
    check("midrst_pulses", {30'd0, done_tick, frame_err}, 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    check("postrst_active", {31'd0, active}, 32'd0);
    check("postrst_dout", {24'd0, dout}, 32'h00);
    idle(1);
    push(1'b0, 8'h3C);
    send_frame(8'h3C, 1'b1);
    idle(2);

    // Break: one framing error, then a clean frame
    push(1'b1, 8'h3C);
    rx = 1'b0;
    repeat (30 * CPB) @(negedge clk);
    idle(2);
    push(1'b0, 8'h81);
    send_frame(8'h81, 1'b1);
    idle(2);

    // Back-to-back frames with no idle gap
    push(1'b0, 8'hA3);
    push(1'b0, 8'h00);
    send_frame(8'hA3, 1'b1);
    send_frame(8'h00, 1'b1);
    idle(2);

    // Short glitch: false start, no pulse
    rx = 1'b0;
    repeat (CPB / 2 - 2) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
    check("glitch_active", {31'd0, active}, 32'd0);
    check("glitch_dout", {24'd0, dout}, 32'h00);
    idle(2);

    check("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
